decoder_stream: RTL
===================

DECODER_STREAM -- requirements
Module: decoder_stream

Interface
REQ-001 Parameter M, default 3, SHALL be the index width in bits (M >= 1).
REQ-002 Parameter N, default 2**M, SHALL be the output width in bits (1 <= N <= 2**M).
REQ-003 Parameter DEPTH, default 2, SHALL be the output buffer depth in entries (DEPTH >= 1).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-006 recv_val  input  1  SHALL mean the upstream message is valid.
REQ-007 recv_rdy  output  1  SHALL mean the block can accept a message this cycle.
REQ-008 recv_msg  input  M  SHALL be the index x to decode.
REQ-009 recv_en  input  1  SHALL be the per-message enable.
REQ-010 recv_mode  input  1  SHALL select the output code: 0 = one-hot, 1 = thermometer. It is ignored unless the REQ-029 feature is compiled in.
REQ-011 send_val  output  1  SHALL mean a decoded result is presented.
REQ-012 send_rdy  input  1  SHALL mean downstream accepts the result this cycle.
REQ-013 send_msg  output  N  SHALL be the decoded word.
REQ-014 send_err  output  1  SHALL flag that the presented result came from an out-of-range index.
REQ-015 err_cnt  output  8  SHALL be a saturating count of accepted out-of-range messages.

Function
REQ-016 Transfer SHALL occur on a port when val and rdy are both 1 at a rising clk edge; nothing else constitutes a transfer.
REQ-017 Each accepted message SHALL be decoded and written into a DEPTH-entry FIFO in the same edge in which it is accepted.
REQ-018 Decode rule: if recv_en=0, the word SHALL be all zeros with err=0.
REQ-019 Decode rule: if recv_en=1 and x >= N, the word SHALL be all zeros with err=1.
REQ-020 Decode rule: if recv_en=1, x < N and one-hot mode, the word SHALL be 1 << x with err=0.
REQ-021 Latency SHALL be one cycle: a message accepted at edge k SHALL appear on send_msg/send_err with send_val=1 after edge k when the FIFO was empty.
REQ-022 There SHALL be no combinational path from recv_* to send_*.
REQ-023 recv_rdy SHALL be 1 when the FIFO holds fewer than DEPTH entries, or when it is full and send_rdy=1 (enqueue and dequeue in the same edge).
REQ-024 send_val SHALL be 1 exactly when the FIFO is non-empty; send_msg and send_err SHALL show the head entry.
REQ-025 A simultaneous enqueue and dequeue SHALL leave the occupancy unchanged and preserve order.
REQ-026 Both FIFO pointers SHALL wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-027 err_cnt SHALL increment by 1 on each accepted message with err=1 and SHALL hold at 255.
REQ-028 send_msg, send_err and send_val SHALL remain stable while send_val=1 and send_rdy=0.

Configuration
REQ-029 When macro DECODER_STREAM_THERMO_EN is defined, recv_mode=1 SHALL produce a thermometer word: bits [x:0] set and all higher bits clear, for recv_en=1 and x < N. REQ-018 and REQ-019 still apply.
REQ-030 When DECODER_STREAM_THERMO_EN is undefined, recv_mode SHALL be ignored, all decodes SHALL be one-hot, and the thermometer logic SHALL not be synthesised.

Reset
REQ-031 While reset=0, independent of clk, the FIFO SHALL be emptied: send_val=0, recv_rdy=0, send_msg=0, send_err=0 and err_cnt=0.
REQ-032 An assertion of reset in the middle of a transfer SHALL discard all buffered entries.
REQ-033 On the first rising edge after reset deasserts, recv_rdy SHALL already be 1 and no transfer SHALL be lost or duplicated.

Verification
REQ-034 Test with M=3, N=6, DEPTH=2. Send x=0..5, en=1, with send_rdy=1 held -> send_msg 000001,000010,...,100000, send_err=0, one result per cycle after a 1-cycle latency.
REQ-035 Send x=6, then x=7, with en=1 -> send_msg=000000, send_err=1 for both, and err_cnt=2.
REQ-036 Send x=5 with en=0 -> send_msg=000000, send_err=0, and err_cnt unchanged.
REQ-037 Hold send_rdy=0 and offer 3 messages -> 2 are accepted, then recv_rdy=0. Release send_rdy -> outputs emerge in order, and the third message is accepted in the same edge as the first dequeue.
REQ-038 With DECODER_STREAM_THERMO_EN defined, send x=3, mode=1 -> send_msg=001111. Without the macro, the same stimulus -> 001000.
REQ-039 Drive 300 out-of-range messages, then pulse reset low mid-stream -> err_cnt holds at 255. During reset, send_val=0 and err_cnt=0.

Source files
------------

// File: rtl/decoder_stream.sv
// decoder_stream: index-to-word decoder with a DEPTH-entry output FIFO.
// Each accepted index is decoded (one-hot, or thermometer when the optional
// feature is built) and queued; out-of-range indices yield a zero word with
// an error flag and bump a saturating 8-bit counter.
// Optional feature: define DECODER_STREAM_THERMO_EN to enable thermometer
// decoding selected by recv_mode; otherwise recv_mode is ignored.
module decoder_stream #(
  parameter int M     = 3,
  parameter int N     = 2**M,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [M-1:0] recv_msg,
  input  logic         recv_en,
  input  logic         recv_mode,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [N-1:0] send_msg,
  output logic         send_err,
  output logic [7:0]   err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [M:0]    X_LIMIT  = (M + 1)'(N);

  logic [N-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] err_mem_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [N-1:0] dec_word;
  logic         dec_err;
  logic         push;
  logic         pop;

`ifndef DECODER_STREAM_THERMO_EN
  logic unused_recv_mode;
  assign unused_recv_mode = recv_mode;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Decode the incoming index into the word and error flag to be queued.
  always_comb begin
    dec_err  = recv_en && ({1'b0, recv_msg} >= X_LIMIT);
    dec_word = '0;
    if (recv_en && !dec_err) begin
      for (int unsigned i = 0; i < N; i++) begin
`ifdef DECODER_STREAM_THERMO_EN
        dec_word[i] = recv_mode ? (M'(i) <= recv_msg) : (M'(i) == recv_msg);
`else
        dec_word[i] = (M'(i) == recv_msg);
`endif
      end
    end
  end

  // Handshake and output view of the FIFO head; outputs are zero when empty.
  always_comb begin
    send_val = (count_q != '0);
    recv_rdy = reset && ((count_q != CNT_FULL) || send_rdy);
    push     = recv_val && recv_rdy;
    pop      = send_val && send_rdy;
    send_msg = send_val ? mem_q[rd_ptr_q] : '0;
    send_err = send_val && err_mem_q[rd_ptr_q];
    err_cnt  = err_cnt_q;
  end

  // Next-state for pointers, occupancy and the saturating error counter.
  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    err_cnt_d = err_cnt_q;
    if (push && dec_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Control state; reset empties the FIFO and clears the error count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]     <= dec_word;
      err_mem_q[wr_ptr_q] <= dec_err;
    end
  end

endmodule
